clk_rst_timebase: RTL and testbench

CLK_RST_TIMEBASE -- requirements
Module: clk_rst_timebase

---
 rtl/clk_rst_timebase.sv | 135 +++++++++++++
 tb/tb_clk_rst_timebase.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_rst_timebase.sv
// Clock/reset timebase: reset synchronizer, RESET/SETTLE/RUN control FSM,
// and a microsecond/millisecond/second tick generator with a 16-bit
// seconds counter. All outputs come straight from flops.
module clk_rst_timebase #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int SYNC_STAGES = 2,
    parameter int READY_DELAY = 16
) (
    input  logic        clock_100mhz,
    input  logic        rst_n_i,
    input  logic        enable_i,
    output logic        rst_sync_n_o,
    output logic        ready_o,
    output logic        tick_us_o,
    output logic        tick_ms_o,
    output logic        tick_s_o,
    output logic [15:0] sec_count_o
);

    localparam int              P           = CLK_FREQ_HZ / 1_000_000;
    localparam int              PW          = (P > 1) ? $clog2(P) : 1;
    localparam logic [PW-1:0]   PRESC_LAST  = PW'(P - 1);
    localparam logic [7:0]      SETTLE_LAST = 8'(READY_DELAY - 1);
    localparam logic [9:0]      CNT_LAST    = 10'd999;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_SETTLE,
        ST_RUN
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    state_e                 state_q, state_d;
    logic [7:0]             settle_q, settle_d;
    logic [PW-1:0]          presc_q, presc_d;
    logic [9:0]             us_cnt_q, us_cnt_d;
    logic [9:0]             ms_cnt_q, ms_cnt_d;
    logic [15:0]            sec_q, sec_d;
    logic                   tick_us_q, tick_ms_q, tick_s_q;
    logic                   run_en, us_wrap, ms_wrap, s_wrap;

    // Reset synchronizer: clears instantly on rst_n_i low, shifts ones in after release.
    always_ff @(posedge clock_100mhz or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n_o = sync_q[SYNC_STAGES-1];

    // Control FSM next state: wait for synchronized release, settle, then run forever.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        unique case (state_q)
            ST_RESET: begin
                if (rst_sync_n_o) begin
                    settle_d = '0;
                    state_d  = (READY_DELAY == 1) ? ST_RUN : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                settle_d = settle_q + 8'd1;
                if (settle_d == SETTLE_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    // Tick chain next state. Each tick is registered from the enable sampled in the
    // cycle the prescaler sits at P-1, so coincident us/ms/s ticks land in one cycle.
    always_comb begin
        run_en   = (state_q == ST_RUN) && enable_i;
        us_wrap  = run_en && (presc_q == PRESC_LAST);
        ms_wrap  = us_wrap && (us_cnt_q == CNT_LAST);
        s_wrap   = ms_wrap && (ms_cnt_q == CNT_LAST);
        presc_d  = presc_q;
        us_cnt_d = us_cnt_q;
        ms_cnt_d = ms_cnt_q;
        sec_d    = sec_q;
        if (run_en) begin
            presc_d = us_wrap ? '0 : presc_q + PW'(1);
        end
        if (us_wrap) begin
            us_cnt_d = ms_wrap ? '0 : us_cnt_q + 10'd1;
        end
        if (ms_wrap) begin
            ms_cnt_d = s_wrap ? '0 : ms_cnt_q + 10'd1;
        end
        if (s_wrap) begin
            sec_d = sec_q + 16'd1;
        end
    end

    // State, counters and tick registers; everything clears asynchronously with rst_n_i.
    always_ff @(posedge clock_100mhz or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_RESET;
            settle_q  <= '0;
            presc_q   <= '0;
            us_cnt_q  <= '0;
            ms_cnt_q  <= '0;
            sec_q     <= '0;
            tick_us_q <= 1'b0;
            tick_ms_q <= 1'b0;
            tick_s_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            presc_q   <= presc_d;
            us_cnt_q  <= us_cnt_d;
            ms_cnt_q  <= ms_cnt_d;
            sec_q     <= sec_d;
            tick_us_q <= us_wrap;
            tick_ms_q <= ms_wrap;
            tick_s_q  <= s_wrap;
        end
    end

    assign ready_o     = (state_q == ST_RUN);
    assign tick_us_o   = tick_us_q;
    assign tick_ms_o   = tick_ms_q;
    assign tick_s_o    = tick_s_q;
    assign sec_count_o = sec_q;

endmodule

// File: tb/tb_clk_rst_timebase.sv
// Bench for clk_rst_timebase: a behavioural model counts enabled RUN cycles and
// derives every output arithmetically; directed scenarios add literal checks.
module tb_clk_rst_timebase;

    localparam int     CLK_FREQ_HZ = 4_000_000;
    localparam int     SYNC_STAGES = 2;
    localparam int     READY_DELAY = 3;
    localparam longint P           = CLK_FREQ_HZ / 1_000_000;
    localparam longint CYC_MS      = P * 1000;
    localparam longint CYC_S       = P * 1000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        rst_sync_n, ready, tick_us, tick_ms, tick_s;
    logic [15:0] sec_count;

    int tests = 0;
    int fails = 0;
    int cycle_no = 0;

    clk_rst_timebase #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .SYNC_STAGES(SYNC_STAGES),
        .READY_DELAY(READY_DELAY)
    ) dut (
        .clock_100mhz(clk),
        .rst_n_i     (rst_n),
        .enable_i    (enable),
        .rst_sync_n_o(rst_sync_n),
        .ready_o     (ready),
        .tick_us_o   (tick_us),
        .tick_ms_o   (tick_ms),
        .tick_s_o    (tick_s),
        .sec_count_o (sec_count)
    );

    always #5 clk = ~clk;

    // Model: m_rel = edges since reset release, m_n = enabled RUN cycles elapsed.
    longint m_n = 0;
    int     m_rel = 0;
    bit     m_us = 0, m_ms = 0, m_s = 0;
    int     preload_seq = 0, preload_seen = 0;
    longint preload_n = 0;

    always @(posedge clk or negedge rst_n) begin
        bit was_run;
        if (!rst_n) begin
            m_n = 0; m_rel = 0; m_us = 0; m_ms = 0; m_s = 0;
        end else begin
            was_run = (m_rel >= SYNC_STAGES + READY_DELAY);
            if (preload_seq != preload_seen) begin
                m_n = preload_n;
                preload_seen = preload_seq;
            end
            m_us = 0; m_ms = 0; m_s = 0;
            if (was_run && enable) begin
                m_n++;
                m_us = (m_n % P) == 0;
                m_ms = (m_n % CYC_MS) == 0;
                m_s  = (m_n % CYC_S) == 0;
            end
            if (m_rel < 1000) m_rel++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle_no);
        end
    endtask

    // One clock: advance to the falling edge and compare all outputs with the model.
    task automatic cyc();
        @(negedge clk);
        cycle_no++;
        chk("m_rst_sync_n", rst_sync_n, (m_rel >= SYNC_STAGES) ? 1 : 0);
        chk("m_ready", ready, (m_rel >= SYNC_STAGES + READY_DELAY) ? 1 : 0);
        chk("m_tick_us", tick_us, m_us);
        chk("m_tick_ms", tick_ms, m_ms);
        chk("m_tick_s", tick_s, m_s);
        chk("m_sec_count", sec_count, 64'((m_n / CYC_S) % 65536));
    endtask

    task automatic wait_us(input int budget, output int n, output bit ok);
        n = 0; ok = 0;
        while (!ok && n < budget) begin
            cyc();
            n++;
            ok = (tick_us === 1'b1);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rst_sync"}, rst_sync_n, 0);
        chk({tag, "_ready"}, ready, 0);
        chk({tag, "_tick_us"}, tick_us, 0);
        chk({tag, "_tick_ms"}, tick_ms, 0);
        chk({tag, "_tick_s"}, tick_s, 0);
        chk({tag, "_sec"}, sec_count, 0);
    endtask

    // Release already happened between edges; rst_sync at edge 2, ready at edge 5.
    task automatic check_seq(input string tag);
        cyc(); chk({tag, "_sync_e1"}, rst_sync_n, 0);
        cyc(); chk({tag, "_sync_e2"}, rst_sync_n, 1);
        chk({tag, "_ready_e2"}, ready, 0);
        cyc(); cyc(); chk({tag, "_ready_e4"}, ready, 0);
        cyc(); chk({tag, "_ready_e5"}, ready, 1);
    endtask

    initial begin
        int  n, us_seen, r0;
        bit  ok;

        // Reset held
        repeat (3) cyc();
        chk_all_zero("reset");
        #1 rst_n = 1'b1;
        check_seq("boot");
        r0 = cycle_no;

        // First us tick after 4 enabled RUN cycles
        wait_us(8, n, ok);
        chk("first_tick_seen", ok, 1);
        chk("first_tick_lat", cycle_no - r0, 4);

        // Millisecond tick coincides with the 1000th us tick at cycle 4000
        us_seen = 1;
        while (ok && tick_ms !== 1'b1 && us_seen < 1100) begin
            wait_us(8, n, ok);
            us_seen++;
            chk("us_period", n, 4);
        end
        chk("ms_seen", (ok && tick_ms === 1'b1) ? 1 : 0, 1);
        chk("ms_us_count", us_seen, 1000);
        chk("ms_cycle", cycle_no - r0, 4000);
        chk("ms_with_us", tick_us, 1);

        // Enable gap with the prescaler at 2
        cyc(); cyc();
        #1 enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("gap_no_us", tick_us, 0);
        end
        #1 enable = 1'b1;
        cyc(); chk("gap_resume_e1", tick_us, 0);
        cyc(); chk("gap_resume_e2", tick_us, 1);

        // Enable dropped exactly in the prescaler's last cycle, then restored
        cyc(); cyc(); cyc();
        #1 enable = 1'b0;
        cyc(); chk("drop_at_last", tick_us, 0);
        #1 enable = 1'b1;
        cyc(); chk("return_at_last", tick_us, 1);

        // Preload counters to one us tick short of a seconds wrap
        #1 enable = 1'b0;
        force dut.presc_q  = 2'd2;
        force dut.us_cnt_q = 10'd999;
        force dut.ms_cnt_q = 10'd999;
        force dut.sec_q    = 16'hFFFF;
        preload_n = 2 + P * 999 + CYC_MS * 999 + CYC_S * 65535;
        preload_seq++;
        cyc();
        #1;
        release dut.presc_q;
        release dut.us_cnt_q;
        release dut.ms_cnt_q;
        release dut.sec_q;
        cyc(); chk("sec_preload", sec_count, 65535);
        #1 enable = 1'b1;
        cyc(); chk("wrap_e1_us", tick_us, 0);
        cyc();
        chk("wrap_us", tick_us, 1);
        chk("wrap_ms", tick_ms, 1);
        chk("wrap_s", tick_s, 1);
        chk("wrap_sec", sec_count, 0);
        chk("wrap_ready", ready, 1);

        // Reset asserted in the cycle a us tick is due
        cyc(); cyc(); cyc();
        #1 rst_n = 1'b0;
        #1 chk_all_zero("midtick");
        chk("midtick_presc", dut.presc_q, 0);
        chk("midtick_us_cnt", dut.us_cnt_q, 0);
        chk("midtick_ms_cnt", dut.ms_cnt_q, 0);
        cyc(); chk_all_zero("midtick_edge");
        #1 rst_n = 1'b1;
        check_seq("after_midtick");

        // 3 ns glitch in RUN
        cyc(); cyc();
        #1 rst_n = 1'b0;
        #1 chk_all_zero("glitch");
        #2 rst_n = 1'b1;
        check_seq("after_glitch");
        r0 = cycle_no;
        wait_us(8, n, ok);
        chk("restart_tick_lat", cycle_no - r0, 4);
        repeat (20) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
